// File: rtl/vector_ram_arbiter.sv
// Round-robin arbiter sharing one vector RAM request port among NUM_REQ requesters,
// with burst locking and an ID FIFO that steers in-order read responses back.
module vector_ram_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int PARALLELISM     = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ-1:0]                        req_write,
    input  logic [NUM_REQ-1:0]                        req_last,
    input  logic [NUM_REQ*PARALLELISM*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                        rsp_valid,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         rsp_rdata,
    output logic                                      ram_valid,
    input  logic                                      ram_ready,
    output logic                                      ram_write,
    output logic [PARALLELISM*ADDR_WIDTH-1:0]         ram_addr,
    output logic [PARALLELISM*DATA_WIDTH-1:0]         ram_wdata,
    input  logic                                      ram_rvalid,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]         ram_rdata,
    output logic                                      busy,
    output logic                                      rsp_err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(RESP_FIFO_DEPTH) + 1;
    localparam int AV = PARALLELISM * ADDR_WIDTH;
    localparam int DV = PARALLELISM * DATA_WIDTH;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_next;
    logic [IW-1:0]       lock_id, lock_id_next;
    logic [IW-1:0]       rr_ptr, rr_ptr_next;
    logic [IW-1:0]       grant, cand;
    logic                has_grant;
    logic [NUM_REQ-1:0]  eligible;
    logic                handshake, push, pop, fifo_full;

    logic [IW-1:0]       fifo_mem [RESP_FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_count;

    // Full check looks only at the registered count; a same-cycle pop never frees a slot.
    assign fifo_full = (fifo_count == CW'(RESP_FIFO_DEPTH));

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & (req_write[i] | ~fifo_full);
        end
    end

    always_comb begin
        grant     = '0;
        cand      = '0;
        has_grant = 1'b0;
        if (state == LOCKED) begin
            grant     = lock_id;
            has_grant = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
                if (!has_grant && eligible[cand]) begin
                    grant     = cand;
                    has_grant = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        ram_valid = 1'b0;
        ram_write = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (has_grant) begin
            req_ready[grant] = ram_ready & eligible[grant];
            ram_valid        = eligible[grant];
            ram_write        = req_write[grant];
            ram_addr         = req_addr[grant*AV +: AV];
            ram_wdata        = req_wdata[grant*DV +: DV];
        end
    end

    assign handshake = ram_valid & ram_ready;
    assign push      = handshake & ~req_write[grant];
    assign pop       = ram_rvalid & (fifo_count != '0);

    always_comb begin
        state_next   = state;
        lock_id_next = lock_id;
        rr_ptr_next  = rr_ptr;
        if (handshake) begin
            if (req_last[grant]) begin
                state_next  = IDLE;
                rr_ptr_next = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end else begin
                state_next   = LOCKED;
                lock_id_next = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
            rr_ptr  <= rr_ptr_next;
        end
    end

    // ID FIFO control; the storage itself needs no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant;
    end

    // Registered response stage: one cycle after the RAM data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= pop ? (NUM_REQ'(1) << fifo_mem[rd_ptr]) : '0;
            if (pop) rsp_rdata <= ram_rdata;
            if (ram_rvalid && fifo_count == '0) rsp_err <= 1'b1;
        end
    end

    assign busy = (state == LOCKED) | (fifo_count != '0);

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Directed bench for vector_ram_arbiter: a small RAM model answers reads one cycle
// after the handshake (or later when stalled); expected values are written out per cycle.
module tb_vector_ram_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid, req_ready, req_write, req_last, rsp_valid;
    logic [119:0] req_addr;
    logic [383:0] req_wdata;
    logic [127:0] rsp_rdata, ram_wdata, ram_rdata;
    logic [39:0]  ram_addr;
    logic         ram_valid, ram_ready, ram_write, ram_rvalid, busy, rsp_err;

    int total = 0;
    int bad   = 0;

    logic [31:0]   mem [1024];
    logic [1023:0] written;
    logic [127:0]  pend [$];
    logic          stall;

    always #5 clk = ~clk;

    vector_ram_arbiter #(
        .NUM_REQ(3), .PARALLELISM(4), .DATA_WIDTH(32), .ADDR_WIDTH(10), .RESP_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
        .busy(busy), .rsp_err(rsp_err)
    );

    // Unwritten words read back as 0xD0000000 + address.
    function automatic logic [31:0] rd_word(input logic [9:0] a);
        return written[a] ? mem[a] : 32'hD000_0000 + 32'(a);
    endfunction

    always @(posedge clk) begin
        if (rst) written <= '0;
        if (ram_valid && ram_ready) begin
            if (ram_write) begin
                for (int j = 0; j < 4; j++) begin
                    mem[ram_addr[j*10 +: 10]]     <= ram_wdata[j*32 +: 32];
                    written[ram_addr[j*10 +: 10]] <= 1'b1;
                end
            end else begin
                pend.push_back({rd_word(ram_addr[39:30]), rd_word(ram_addr[29:20]),
                                rd_word(ram_addr[19:10]), rd_word(ram_addr[9:0])});
            end
        end
        if (!stall && pend.size() != 0) begin
            ram_rvalid <= 1'b1;
            ram_rdata  <= pend.pop_front();
        end else begin
            ram_rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input bit l,
                           input int a0, input int step, input logic [31:0] wd);
        req_valid[i] = v;
        req_write[i] = w;
        req_last[i]  = l;
        for (int j = 0; j < 4; j++) begin
            req_addr[(i*4+j)*10 +: 10]  = 10'(a0 + j*step);
            req_wdata[(i*4+j)*32 +: 32] = wd;
        end
    endtask

    function automatic logic [127:0] rd_exp(input int a0, input int step);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'hD000_0000 + 32'(a0 + j*step);
        return r;
    endfunction

    function automatic logic [39:0] addr_exp(input int a0, input int step);
        logic [39:0] r;
        for (int j = 0; j < 4; j++) r[j*10 +: 10] = 10'(a0 + j*step);
        return r;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) set_req(i, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ram_ready = 1'b1;
        stall = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_valid = '0;
        req_write = '0;
        req_last = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_rsp_rdata", rsp_rdata, 128'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ram_valid", ram_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat reads from all three: grant 0,1,2,... and responses two cycles later.
        set_req(0, 1, 0, 1, 0, 1, 32'h0);
        set_req(1, 1, 0, 1, 16, 1, 32'h0);
        set_req(2, 1, 0, 1, 32, 1, 32'h0);
        for (int c = 0; c < 8; c++) begin
            if (c == 6) idle_all();
            #1;
            if (c < 6) begin
                check("rr_ready", req_ready, 128'(1 << (c % 3)));
                check("rr_addr", ram_addr, addr_exp(16 * (c % 3), 1));
            end
            if (c >= 2) begin
                check("rr_rsp_valid", rsp_valid, 128'(1 << ((c - 2) % 3)));
                check("rr_rsp_rdata", rsp_rdata, rd_exp(16 * ((c - 2) % 3), 1));
            end else begin
                check("rr_rsp_none", rsp_valid, 3'b000);
            end
            @(negedge clk);
        end

        // Four-beat write burst from requester 1 holds the grant; then 2, then 0.
        set_req(1, 1, 1, 0, 100, 1, 32'h11);
        #1; check("burst_b1", req_ready, 3'b010); check("burst_idle_busy", busy, 1'b0);
        @(negedge clk);
        set_req(0, 1, 1, 1, 200, 1, 32'h22);
        set_req(2, 1, 1, 1, 210, 1, 32'h33);
        #1; check("burst_b2", req_ready, 3'b010); check("burst_busy", busy, 1'b1);
        @(negedge clk);
        #1; check("burst_b3", req_ready, 3'b010);
        @(negedge clk);
        set_req(1, 1, 1, 1, 100, 1, 32'h11);
        #1; check("burst_b4", req_ready, 3'b010);
        @(negedge clk);
        set_req(1, 0, 0, 0, 0, 0, 32'h0);
        #1; check("burst_next2", req_ready, 3'b100);
        @(negedge clk);
        set_req(2, 0, 0, 0, 0, 0, 32'h0);
        #1; check("burst_next0", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        #1; check("burst_done_busy", busy, 1'b0);
        @(negedge clk);

        // Stalled read data: the fifth read waits while a write still gets through.
        stall = 1'b1;
        set_req(0, 1, 0, 1, 300, 1, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1; check("full_fill", req_ready, 3'b001);
            @(negedge clk);
        end
        set_req(2, 1, 1, 1, 220, 1, 32'h44);
        #1;
        check("full_rd_blocked_wr_ok", req_ready, 3'b100);
        check("full_ram_write", ram_write, 1'b1);
        check("full_busy", busy, 1'b1);
        @(negedge clk);
        set_req(2, 0, 0, 0, 0, 0, 32'h0);
        stall = 1'b0;
        #1; check("full_blocked", req_ready, 3'b000); check("full_ram_valid", ram_valid, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        #1; check("full_same_cycle_pop", req_ready, 3'b000);
        @(negedge clk);
        #1;
        check("full_accept5", req_ready, 3'b001);
        check("full_rsp_valid", rsp_valid, 3'b001);
        check("full_rsp_rdata", rsp_rdata, rd_exp(300, 1));
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        stall = 1'b0;
        for (int c = 8; c < 15; c++) begin
            #1;
            if (c >= 10 && c <= 13) check("full_drain_valid", rsp_valid, 3'b001);
            if (c == 14) begin
                check("full_drain_busy", busy, 1'b0);
                check("full_drain_none", rsp_valid, 3'b000);
                check("full_no_err", rsp_err, 1'b0);
            end
            @(negedge clk);
        end

        // Write 0xA5 at address 7 from requester 0, read it back through requester 2.
        set_req(0, 1, 1, 1, 7, 0, 32'hA5);
        #1; check("wr_rd_wr", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        set_req(2, 1, 0, 1, 7, 0, 32'h0);
        #1; check("wr_rd_rd", req_ready, 3'b100);
        @(negedge clk);
        set_req(2, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        check("wr_rd_rsp_valid", rsp_valid, 3'b100);
        check("wr_rd_rsp_rdata", rsp_rdata, {4{32'h0000_00A5}});
        @(negedge clk);

        // RAM not ready: request holds, address stable, round-robin pointer unchanged.
        ram_ready = 1'b0;
        set_req(0, 1, 1, 1, 500, 1, 32'h55);
        set_req(1, 1, 1, 1, 510, 1, 32'h66);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", req_ready, 3'b000);
            check("stall_ram_valid", ram_valid, 1'b1);
            check("stall_addr", ram_addr, addr_exp(500, 1));
            @(negedge clk);
        end
        ram_ready = 1'b1;
        #1; check("stall_release", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        #1; check("stall_next", req_ready, 3'b010);
        @(negedge clk);
        set_req(1, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);

        // Reset mid-burst with two reads outstanding; the late RAM data is stale.
        stall = 1'b1;
        set_req(0, 1, 0, 1, 600, 1, 32'h0);
        #1; check("rstb_rd0", req_ready, 3'b001);
        @(negedge clk);
        #1; check("rstb_rd1", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        set_req(1, 1, 1, 0, 700, 1, 32'h77);
        #1; check("rstb_lock", req_ready, 3'b010);
        @(negedge clk);
        #1; check("rstb_busy", busy, 1'b1);
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        #1;
        check("rstb_busy0", busy, 1'b0);
        check("rstb_rsp_valid0", rsp_valid, 3'b000);
        check("rstb_rsp_rdata0", rsp_rdata, 128'h0);
        check("rstb_rsp_err0", rsp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        set_req(0, 1, 1, 1, 800, 1, 32'h88);
        set_req(1, 1, 1, 1, 810, 1, 32'h99);
        #1; check("rstb_rr_restart", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 0, 0, 0, 0, 0, 32'h0);
        #1; check("rstb_next", req_ready, 3'b010); check("rstb_stale_none", rsp_valid, 3'b000);
        @(negedge clk);
        set_req(1, 0, 0, 0, 0, 0, 32'h0);
        for (int c = 7; c < 10; c++) begin
            #1;
            check("rstb_stale_none", rsp_valid, 3'b000);
            check("rstb_err", rsp_err, 1'b1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
